lua_mem_responder: RTL and testbench

LUA_MEM_RESPONDER -- requirements
Module: lua_mem_responder

---
 rtl/lua_mem_responder_if.sv | 27 ++
 rtl/lua_mem_responder.sv | 105 ++++++++++
 tb/tb_lua_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lua_mem_responder_if.sv
// rtl/lua_mem_responder_if.sv - Avalon-MM slave bus bundle for the memory responder
interface lua_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output waitrequest
    );
endinterface

// File: rtl/lua_mem_responder.sv
// rtl/lua_mem_responder.sv - Avalon-MM word memory responder with fixed wait states
module lua_mem_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  clock_sink_clk,
    input  logic                  reset_sink_reset_n,
    lua_mem_responder_if.slave    avalon_slave,
    input  logic                  preload_en,
    input  logic [ADDR_WIDTH-1:0] preload_addr,
    input  logic [31:0]           preload_data,
    input  logic                  err_clr,
    output logic                  err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int          DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LIMIT = 4'(WAIT_CYCLES);
    // Byte span of the memory, one bit wider than the bus so the top of a
    // full 4 GiB window cannot wrap.
    localparam logic [32:0] SPAN       = 33'(DEPTH) << 2;

    logic [31:0]           mem [DEPTH];
    logic [3:0]            wcnt;
    logic                  req;
    logic                  accept;
    logic                  in_range;
    logic                  bad_xfer;
    logic [32:0]           offset;
    logic [ADDR_WIDTH-1:0] word_idx;

    assign req    = avalon_slave.read | avalon_slave.write;
    assign accept = req && (wcnt == WAIT_LIMIT);
    assign avalon_slave.waitrequest = req && (wcnt != WAIT_LIMIT);

    // Address decode: offset is computed wide so addresses below the base
    // are caught by the explicit lower-bound compare rather than wrapping.
    assign offset   = {1'b0, avalon_slave.address} - {1'b0, BASE_ADDR};
    assign in_range = (avalon_slave.address[1:0] == 2'b00) &&
                      (avalon_slave.address >= BASE_ADDR) &&
                      (offset < SPAN);
    assign word_idx = offset[ADDR_WIDTH+1:2];

    // Bad address or both strobes at once both flag a protocol error.
    assign bad_xfer = !in_range || (avalon_slave.read && avalon_slave.write);

    // Wait-state counter: counts stall cycles, restarts after accept or drop.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            wcnt <= 4'd0;
        end else if (!req || accept) begin
            wcnt <= 4'd0;
        end else begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Memory write port: backdoor preload first so an accepted bus write to
    // the same word on the same edge overrides it.
    always_ff @(posedge clock_sink_clk) begin
        if (preload_en) begin
            mem[preload_addr] <= preload_data;
        end
        if (accept && avalon_slave.write && in_range) begin
            mem[word_idx] <= avalon_slave.writedata;
        end
    end

    // Read data is only meaningful in the accept cycle of a pure read; it
    // reflects the contents before this edge's writes.
    always_comb begin
        avalon_slave.readdata = 32'h0;
        if (accept && !avalon_slave.write) begin
            avalon_slave.readdata = in_range ? mem[word_idx] : 32'hDEAD_BEEF;
        end
    end

    // Sticky error flag; a new error outranks a simultaneous clear.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            err <= 1'b0;
        end else if (accept && bad_xfer) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Accepted-transfer counters; a dual-strobe transfer counts as a write.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (accept) begin
            if (avalon_slave.write) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lua_mem_responder.sv
// tb/tb_lua_mem_responder.sv - scoreboard bench for lua_mem_responder
module tb_lua_mem_responder;

    localparam int WAITS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lua_mem_responder_if bus2 ();
    lua_mem_responder_if bus0 ();

    logic        pl_en2 = 1'b0;
    logic [7:0]  pl_addr2 = '0;
    logic [31:0] pl_data2 = '0;
    logic        err_clr2 = 1'b0;
    logic        err2;
    logic [15:0] rd_cnt2, wr_cnt2;

    logic        err0;
    logic [15:0] rd_cnt0, wr_cnt0;

    lua_mem_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(WAITS)) u_dut2 (
        .clock_sink_clk     (clk),
        .reset_sink_reset_n (rst_n),
        .avalon_slave       (bus2.slave),
        .preload_en         (pl_en2),
        .preload_addr       (pl_addr2),
        .preload_data       (pl_data2),
        .err_clr            (err_clr2),
        .err                (err2),
        .rd_count           (rd_cnt2),
        .wr_count           (wr_cnt2)
    );

    lua_mem_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clock_sink_clk     (clk),
        .reset_sink_reset_n (rst_n),
        .avalon_slave       (bus0.slave),
        .preload_en         (1'b0),
        .preload_addr       (8'h00),
        .preload_data       (32'h0),
        .err_clr            (1'b0),
        .err                (err0),
        .rd_count           (rd_cnt0),
        .wr_count           (wr_cnt0)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: plain word array plus counters.
    logic [31:0] m_mem [256];
    int          m_rd = 0;
    int          m_wr = 0;
    bit          m_err = 0;

    function automatic bit tb_in_range(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'd1024);
    endfunction

    typedef struct {
        logic [31:0] data;
        int          stalls;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: counts stalls and scores every accepted transfer.
    int stall_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (bus2.read || bus2.write) begin
            if (bus2.waitrequest) begin
                stall_cnt++;
                check("stall_readdata", bus2.readdata, 32'h0);
            end else begin
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("readdata", bus2.readdata, e.data);
                    check("stall_cycles", stall_cnt, e.stalls);
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    task automatic idle();
        bus2.read = 1'b0;
        bus2.write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        pl_en2 = 1'b1; pl_addr2 = idx; pl_data2 = d;
        m_mem[idx] = d;
        @(posedge clk); #1;
        pl_en2 = 1'b0;
    endtask

    task automatic clear_err();
        err_clr2 = 1'b1;
        m_err = 0;
        @(posedge clk); #1;
        err_clr2 = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rd_count"}, rd_cnt2, 32'(m_rd[15:0]));
        check({tag, "_wr_count"}, wr_cnt2, 32'(m_wr[15:0]));
        check({tag, "_err"}, err2, 32'(m_err));
    endtask

    // Issue one transfer and hold it until accepted. Optionally scramble
    // address/data during stalls and pulse a preload in the accept cycle.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble,
                        input bit pl, input logic [7:0] pl_idx, input logic [31:0] pl_d);
        exp_t e;
        bit   acc = 0;
        bit   ok = tb_in_range(addr);
        e.stalls = WAITS;
        e.data = 32'h0;
        if (wr) begin
            if (pl) m_mem[pl_idx] = pl_d;
            if (ok) m_mem[addr / 4] = data;
            m_wr++;
        end else begin
            e.data = ok ? m_mem[addr / 4] : 32'hDEAD_BEEF;
            if (pl) m_mem[pl_idx] = pl_d;
            m_rd++;
        end
        if (!ok || (rd && wr)) m_err = 1;
        exp_q.push_back(e);
        for (int k = 0; k < 40; k++) begin
            bus2.read = rd;
            bus2.write = wr;
            if (scramble && k < WAITS) begin
                bus2.address = $urandom;
                bus2.writedata = $urandom;
            end else begin
                bus2.address = addr;
                bus2.writedata = data;
            end
            pl_en2 = pl && (k == WAITS);
            pl_addr2 = pl_idx;
            pl_data2 = pl_d;
            @(negedge clk);
            if (!bus2.waitrequest) begin
                acc = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("accept_within_bound", 32'(acc), 32'd1);
        @(posedge clk); #1;
        pl_en2 = 1'b0;
    endtask

    initial begin
        bus2.read = 0; bus2.write = 0; bus2.address = 0; bus2.writedata = 0;
        bus0.read = 0; bus0.write = 0; bus0.address = 0; bus0.writedata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_err", err2, 32'd0);
        check("reset_rd_count", rd_cnt2, 32'd0);
        check("reset_wr_count", wr_cnt2, 32'd0);
        check("reset_waitrequest", bus2.waitrequest, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) preload(8'(i), 32'hA5A5_0000 ^ i * 32'h0101_0101);

        // Basic read after preload
        preload(8'd3, 32'h1234_5678);
        xfer(1, 0, 32'hC, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("basic_read");

        // Back-to-back write then read
        xfer(0, 1, 32'h10, 32'hCAFE_F00D, 0, 0, 0, 0);
        xfer(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("b2b");

        // Misaligned and out-of-range reads
        xfer(1, 0, 32'h2, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("misaligned");
        clear_err();
        check_state("clear1");
        xfer(1, 0, 32'h400, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("out_of_range");
        clear_err();
        check_state("clear2");

        // Dropped request then reissue
        bus2.read = 1; bus2.address = 32'hC;
        @(negedge clk);
        @(posedge clk); #1;
        bus2.read = 0;
        @(posedge clk); #1;
        xfer(1, 0, 32'hC, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("abort");

        // Dual strobe executes as write and flags an error
        xfer(1, 1, 32'h20, 32'h5555_AAAA, 0, 0, 0, 0);
        xfer(1, 0, 32'h20, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("dual");
        clear_err();

        // Out-of-range write discarded (would alias word 0 if truncated)
        xfer(0, 1, 32'h400, 32'hBAD0_BAD0, 0, 0, 0, 0);
        xfer(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        idle();
        clear_err();

        // Stall-time address/data changes ignored
        xfer(0, 1, 32'h40, 32'h0BAD_CAFE, 1, 0, 0, 0);
        xfer(1, 0, 32'h40, 32'h0, 1, 0, 0, 0);
        idle();

        // Preload colliding with accepted write / read on the same edge
        xfer(0, 1, 32'h1C, 32'h7777_7777, 0, 1, 8'd7, 32'h8888_8888);
        xfer(1, 0, 32'h1C, 32'h0, 0, 0, 0, 0);
        xfer(1, 0, 32'h24, 32'h0, 0, 1, 8'd9, 32'h9999_0000);
        xfer(1, 0, 32'h24, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("preload_collide");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int          kind = $urandom_range(0, 9);
            bit          wr = 1'($urandom_range(0, 1));
            bit          rd = !wr || ($urandom_range(0, 9) == 0);
            logic [31:0] a;
            if (kind < 8) a = 32'($urandom_range(0, 255)) * 4;
            else if (kind == 8) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            else a = 32'd1024 + 32'($urandom_range(0, 1000)) * 4;
            xfer(rd, wr, a, $urandom, 1'($urandom_range(0, 1)), 0, 0, 0);
            if ($urandom_range(0, 3) == 0) idle();
            if ($urandom_range(0, 7) == 0) begin
                idle();
                clear_err();
            end
        end
        idle();
        check_state("random");

        // Zero-wait instance: write then read on consecutive cycles
        bus0.write = 1; bus0.address = 32'h20; bus0.writedata = 32'h0F0F_1234;
        @(negedge clk);
        check("w0_write_waitrequest", bus0.waitrequest, 32'd0);
        check("w0_write_readdata", bus0.readdata, 32'h0);
        @(posedge clk); #1;
        bus0.write = 0; bus0.read = 1;
        @(negedge clk);
        check("w0_read_waitrequest", bus0.waitrequest, 32'd0);
        check("w0_read_readdata", bus0.readdata, 32'h0F0F_1234);
        @(posedge clk); #1;
        bus0.read = 0;
        check("w0_rd_count", rd_cnt0, 32'd1);
        check("w0_wr_count", wr_cnt0, 32'd1);
        check("w0_err", err0, 32'd0);

        // Reset during the stall of a write
        preload(8'd9, 32'h1111_2222);
        bus2.write = 1; bus2.address = 32'h24; bus2.writedata = 32'h9999_9999;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        m_rd = 0; m_wr = 0; m_err = 0;
        check_state("reset_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus2.write = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 0, 32'h24, 32'h0, 0, 0, 0, 0);
        idle();
        check_state("after_reset");
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
